// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus initiator.
// Also holds the helpers that turn the configured wait-state count into a wait-counter load value.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Reads always spend at least one cycle in WAIT; writes only when wait states are configured.
  function automatic logic needs_wait(input logic we, input logic [WAIT_CNT_W-1:0] ws);
    return (!we) || (ws != {WAIT_CNT_W{1'b0}});
  endfunction

  // WAIT lasts load+1 cycles: reads need 1+ws cycles, writes need ws cycles.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input logic we,
                                                      input logic [WAIT_CNT_W-1:0] ws);
    return we ? (ws - {{(WAIT_CNT_W-1){1'b0}}, 1'b1}) : ws;
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Requester, response and memory-side signals of the bus initiator.
// The master modport is the initiator's view; the slave modport is the requester/memory view.
interface mem_initiator_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_initiator_checker.sv
// Protocol properties of the initiator bus, observed from its ports only.
module mem_initiator_checker (
  input logic clk,
  input logic rst_n,
  input logic req_valid,
  input logic req_ready,
  input logic rsp_valid,
  input logic busy,
  input logic mem_rd,
  input logic mem_wr
);

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rd && mem_wr))
    else $error("mem_rd and mem_wr high together");

  // A strobe can only appear in the cycle directly after an accept, i.e. ISSUE.
  a_strobe_issue: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_rd || mem_wr) |-> (busy && !req_ready && $past(req_valid && req_ready)))
    else $error("memory strobe outside ISSUE");

  a_rsp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |=> !rsp_valid)
    else $error("rsp_valid high for two consecutive cycles");

endmodule

// File: rtl/mem_wait_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module mem_wait_timer
  import mem_bus_pkg::*;
#(
  parameter int W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Load has priority; counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding bus initiator for the 64K x 8 synchronous memory.
// Every output is a flop; nothing on req_* reaches mem_* combinationally.
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst_n,
  mem_initiator_if.master bus
);

  localparam logic [WAIT_CNT_W-1:0] WS_C = WAIT_CNT_W'(WAIT_STATES);

  state_e              state_r;
  state_e              state_nxt_s;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                mem_rd_r;
  logic                mem_wr_r;
  logic                req_ready_r;
  logic                busy_r;
  logic                rsp_valid_r;
  logic                accept_s;
  logic                capture_s;
  logic                timer_load_s;
  logic                timer_en_s;
  logic                timer_done_s;
  logic [WAIT_CNT_W-1:0] timer_val_s;

  assign accept_s = (state_r == IDLE) && bus.req_valid;

  mem_wait_timer #(
    .W (WAIT_CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .en       (timer_en_s),
    .done     (timer_done_s)
  );

  // Next-state decode, wait-timer control and read-data capture strobe.
  always_comb begin
    state_nxt_s  = state_r;
    timer_load_s = 1'b0;
    timer_val_s  = {WAIT_CNT_W{1'b0}};
    timer_en_s   = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        timer_val_s = wait_load(we_r, WS_C);
        if (needs_wait(we_r, WS_C)) begin
          state_nxt_s  = WAIT;
          timer_load_s = 1'b1;
        end else begin
          state_nxt_s  = RESP;
        end
      end
      WAIT: begin
        timer_en_s = 1'b1;
        if (timer_done_s) begin
          state_nxt_s = RESP;
          capture_s   = ~we_r;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, transaction latches and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= (state_nxt_s == IDLE);
      busy_r      <= (state_nxt_s != IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
      // Strobes are high exactly for the ISSUE cycle following an accept.
      mem_rd_r    <= accept_s && !bus.req_we;
      mem_wr_r    <= accept_s && bus.req_we;
      if (accept_s) begin
        we_r    <= bus.req_we;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
      end
      if (capture_s) begin
        rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_rd    = mem_rd_r;
  assign bus.mem_wr    = mem_wr_r;

endmodule
